// File: rtl/peri1_reg_arb.sv
// Round-robin arbiter sharing the peripheral-1 register bus between the wishbone
// bridge (requester 0) and the core peripheral path (requester 1), with a watchdog timeout.
module peri1_reg_arb #(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = 32'hFFFF_FFFF
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        m0_reg_cs,
    input  logic        m0_reg_wr,
    input  logic [10:0] m0_reg_addr,
    input  logic [31:0] m0_reg_wdata,
    input  logic [3:0]  m0_reg_be,
    output logic [31:0] m0_reg_rdata,
    output logic        m0_reg_ack,
    input  logic        m1_reg_cs,
    input  logic        m1_reg_wr,
    input  logic [10:0] m1_reg_addr,
    input  logic [31:0] m1_reg_wdata,
    input  logic [3:0]  m1_reg_be,
    output logic [31:0] m1_reg_rdata,
    output logic        m1_reg_ack,
    output logic        s_reg_cs,
    output logic        s_reg_wr,
    output logic [10:0] s_reg_addr,
    output logic [31:0] s_reg_wdata,
    output logic [3:0]  s_reg_be,
    input  logic [31:0] s_reg_rdata,
    input  logic        s_reg_ack,
    input  logic        err_clr,
    output logic [1:0]  err_sts
);
    localparam int CW = $clog2(TIMEOUT_CYC);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state;
    logic          gnt;
    logic          last_gnt;
    logic [CW-1:0] cnt;

    logic        busy;
    logic        sel_cs;
    logic        ack_ok;
    logic        ack_to;
    logic        abort;
    logic        cpl;
    logic [31:0] cpl_rdata;
    logic [1:0]  err_set;

    assign busy   = (state == BUSY);
    assign sel_cs = gnt ? m1_reg_cs : m0_reg_cs;

    // A slave ack on the last watchdog cycle takes precedence over the timeout.
    assign ack_ok = busy && s_reg_ack;
    assign ack_to = busy && sel_cs && !s_reg_ack && (cnt == CW'(TIMEOUT_CYC - 1));
    assign abort  = busy && !sel_cs && !s_reg_ack;
    assign cpl    = ack_ok || ack_to;

    assign cpl_rdata = ack_ok ? s_reg_rdata : ERR_RDATA;
    assign err_set   = {ack_to && gnt, ack_to && !gnt};

    assign m0_reg_ack   = cpl && !gnt;
    assign m1_reg_ack   = cpl && gnt;
    assign m0_reg_rdata = m0_reg_ack ? cpl_rdata : '0;
    assign m1_reg_rdata = m1_reg_ack ? cpl_rdata : '0;

    // Slave side is a straight mux of the granted requester, forced to zero outside BUSY.
    assign s_reg_cs    = busy && sel_cs;
    assign s_reg_wr    = busy && (gnt ? m1_reg_wr : m0_reg_wr);
    assign s_reg_addr  = busy ? (gnt ? m1_reg_addr  : m0_reg_addr)  : '0;
    assign s_reg_wdata = busy ? (gnt ? m1_reg_wdata : m0_reg_wdata) : '0;
    assign s_reg_be    = busy ? (gnt ? m1_reg_be    : m0_reg_be)    : '0;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= '0;
            err_sts  <= '0;
        end else begin
            // Clear and set in the same cycle: set wins.
            err_sts <= (err_clr ? 2'b00 : err_sts) | err_set;
            case (state)
                IDLE: begin
                    if (m0_reg_cs || m1_reg_cs) begin
                        state <= BUSY;
                        cnt   <= '0;
                        gnt   <= (m0_reg_cs && m1_reg_cs) ? !last_gnt : m1_reg_cs;
                    end
                end
                BUSY: begin
                    if (cpl || abort) begin
                        state    <= IDLE;
                        last_gnt <= gnt;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peri1_reg_arb.sv
// Self-checking bench for peri1_reg_arb: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_peri1_reg_arb;
    localparam int          T       = 8;
    localparam logic [31:0] ERR     = 32'hFFFF_FFFF;
    localparam logic        M0_WR   = 1'b0;
    localparam logic [10:0] M0_ADDR = 11'h080;
    localparam logic [31:0] M0_WD   = 32'h1111_2222;
    localparam logic [3:0]  M0_BE   = 4'hF;
    localparam logic        M1_WR   = 1'b1;
    localparam logic [10:0] M1_ADDR = 11'h104;
    localparam logic [31:0] M1_WD   = 32'hA5A5_0F0F;
    localparam logic [3:0]  M1_BE   = 4'b0011;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_reg_cs = 0, m0_reg_wr = 0, m1_reg_cs = 0, m1_reg_wr = 0;
    logic [10:0] m0_reg_addr = 0, m1_reg_addr = 0;
    logic [31:0] m0_reg_wdata = 0, m1_reg_wdata = 0;
    logic [3:0]  m0_reg_be = 0, m1_reg_be = 0;
    logic [31:0] m0_reg_rdata, m1_reg_rdata;
    logic        m0_reg_ack, m1_reg_ack;
    logic        s_reg_cs, s_reg_wr;
    logic [10:0] s_reg_addr;
    logic [31:0] s_reg_wdata;
    logic [3:0]  s_reg_be;
    logic [31:0] s_reg_rdata = 0;
    logic        s_reg_ack = 0;
    logic        err_clr = 0;
    logic [1:0]  err_sts;

    always #5 mclk = ~mclk;

    peri1_reg_arb #(.TIMEOUT_CYC(T), .ERR_RDATA(ERR)) dut (
        .mclk(mclk), .reset(reset),
        .m0_reg_cs(m0_reg_cs), .m0_reg_wr(m0_reg_wr), .m0_reg_addr(m0_reg_addr),
        .m0_reg_wdata(m0_reg_wdata), .m0_reg_be(m0_reg_be),
        .m0_reg_rdata(m0_reg_rdata), .m0_reg_ack(m0_reg_ack),
        .m1_reg_cs(m1_reg_cs), .m1_reg_wr(m1_reg_wr), .m1_reg_addr(m1_reg_addr),
        .m1_reg_wdata(m1_reg_wdata), .m1_reg_be(m1_reg_be),
        .m1_reg_rdata(m1_reg_rdata), .m1_reg_ack(m1_reg_ack),
        .s_reg_cs(s_reg_cs), .s_reg_wr(s_reg_wr), .s_reg_addr(s_reg_addr),
        .s_reg_wdata(s_reg_wdata), .s_reg_be(s_reg_be),
        .s_reg_rdata(s_reg_rdata), .s_reg_ack(s_reg_ack),
        .err_clr(err_clr), .err_sts(err_sts)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    endtask

    task automatic next_cyc();
        @(posedge mclk);
        #1;
    endtask

    function automatic logic [127:0] outs();
        return {13'b0, s_reg_cs, s_reg_wr, s_reg_addr, s_reg_wdata, s_reg_be,
                m0_reg_ack, m0_reg_rdata, m1_reg_ack, m1_reg_rdata};
    endfunction

    function automatic logic [127:0] pack(input logic cs, input logic wr, input logic [10:0] a,
                                          input logic [31:0] wd, input logic [3:0] be,
                                          input logic a0, input logic [31:0] r0,
                                          input logic a1, input logic [31:0] r1);
        return {13'b0, cs, wr, a, wd, be, a0, r0, a1, r1};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        m0_reg_cs = 0; m1_reg_cs = 0; s_reg_ack = 0; err_clr = 0;
        repeat (2) @(posedge mclk);
        #1 reset = 1'b0;
    endtask

    task automatic set_fixed_fields();
        m0_reg_wr = M0_WR; m0_reg_addr = M0_ADDR; m0_reg_wdata = M0_WD; m0_reg_be = M0_BE;
        m1_reg_wr = M1_WR; m1_reg_addr = M1_ADDR; m1_reg_wdata = M1_WD; m1_reg_be = M1_BE;
    endtask

    // Run one transaction; slave acks on BUSY cycle ack_at (1-based), 0 = never.
    task automatic txn(input int r, input int ack_at, input logic [31:0] rd,
                       output int ack_cyc, output logic [31:0] got, output logic oth);
        int nb;
        ack_cyc = -1; got = '0; oth = 1'b0; nb = 0;
        if (r == 0) m0_reg_cs = 1'b1; else m1_reg_cs = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_reg_ack = 1'b0;
            #1;
            if (s_reg_cs) nb++;
            if (s_reg_cs && nb == ack_at) begin s_reg_ack = 1'b1; s_reg_rdata = rd; end
            #2;
            if (r == 0 ? m0_reg_ack : m1_reg_ack) begin
                ack_cyc = k;
                got = (r == 0) ? m0_reg_rdata : m1_reg_rdata;
            end
            if (r == 0 ? m1_reg_ack : m0_reg_ack) oth = 1'b1;
            next_cyc();
            if (ack_cyc >= 0) break;
        end
        m0_reg_cs = 0; m1_reg_cs = 0; s_reg_ack = 0;
    endtask

    typedef struct {
        logic c0, c1, sack;
        logic [31:0] srd;
        int eg;
        logic a0, a1;
    } vec_t;

    function automatic vec_t mk(input logic c0, input logic c1, input logic sack,
                                input logic [31:0] srd, input int eg, input logic a0, input logic a1);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.sack = sack; v.srd = srd; v.eg = eg; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    function automatic logic [127:0] vexp(input vec_t v);
        logic [31:0] r0, r1;
        r0 = v.a0 ? v.srd : 32'h0;
        r1 = v.a1 ? v.srd : 32'h0;
        if (v.eg == 0) return pack(1'b1, M0_WR, M0_ADDR, M0_WD, M0_BE, v.a0, r0, v.a1, r1);
        if (v.eg == 1) return pack(1'b1, M1_WR, M1_ADDR, M1_WD, M1_BE, v.a0, r0, v.a1, r1);
        return pack(1'b0, 1'b0, 11'h0, 32'h0, 4'h0, v.a0, r0, v.a1, r1);
    endfunction

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ac, nseq;
        int nack[2];
        logic [31:0] got;
        logic oth;
        bit ja[2];

        // ---------------- reset values ----------------
        m0_reg_cs = 1'b1; s_reg_ack = 1'b1; s_reg_rdata = 32'h5555_AAAA;
        next_cyc();
        #2;
        chk("reset_outs", outs(), '0);
        chk("reset_err", err_sts, 2'b00);
        do_reset();
        set_fixed_fields();

        // ---------------- vector table ----------------
        tbl[0]  = mk(1, 0, 0, 32'h0,         -1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 32'h0,          0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 32'h0,          0, 0, 0);
        tbl[3]  = mk(1, 0, 1, 32'h1234_5678,  0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 32'h0,         -1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 32'h0,         -1, 0, 0);
        tbl[6]  = mk(0, 1, 0, 32'h0,          1, 0, 0);
        tbl[7]  = mk(0, 1, 1, 32'hDEAD_BEEF,  1, 0, 1);
        tbl[8]  = mk(0, 0, 1, 32'hCAFE_F00D, -1, 0, 0);
        tbl[9]  = mk(1, 1, 0, 32'h0,         -1, 0, 0);
        tbl[10] = mk(1, 1, 1, 32'h0000_0011,  0, 1, 0);
        tbl[11] = mk(0, 1, 0, 32'h0,         -1, 0, 0);
        tbl[12] = mk(0, 1, 1, 32'h0000_0022,  1, 0, 1);
        tbl[13] = mk(0, 0, 0, 32'h0,         -1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            m0_reg_cs = tbl[i].c0; m1_reg_cs = tbl[i].c1;
            s_reg_ack = tbl[i].sack; s_reg_rdata = tbl[i].srd;
            #3;
            chk($sformatf("vec%0d", i), outs(), vexp(tbl[i]));
            next_cyc();
        end
        s_reg_ack = 0;

        // ---------------- strict alternation ----------------
        do_reset();
        s_reg_ack = 1'b1; s_reg_rdata = 32'h0;
        nseq = 0; nack[0] = 0; nack[1] = 0; ja[0] = 0; ja[1] = 0;
        for (int k = 0; k < 80 && nseq < 10; k++) begin
            m0_reg_cs = !ja[0]; m1_reg_cs = !ja[1];
            #3;
            ja[0] = m0_reg_ack; ja[1] = m1_reg_ack;
            if (m0_reg_ack || m1_reg_ack) begin
                chk("alt_single_ack", m0_reg_ack & m1_reg_ack, 1'b0);
                chk("alt_order", m1_reg_ack, nseq % 2);
                if (m0_reg_ack) nack[0]++;
                if (m1_reg_ack) nack[1]++;
                nseq++;
            end
            next_cyc();
        end
        chk("alt_total", nseq, 10);
        chk("alt_m0", nack[0], 5);
        chk("alt_m1", nack[1], 5);
        m0_reg_cs = 0; m1_reg_cs = 0; s_reg_ack = 0;
        next_cyc();

        // ---------------- timeout, clear, recovery ----------------
        do_reset();
        txn(0, 0, 32'h0, ac, got, oth);
        chk("to_ack_cyc", ac, 8);
        chk("to_rdata", got, ERR);
        chk("to_other", oth, 1'b0);
        #1 chk("to_err_set", err_sts, 2'b01);
        err_clr = 1'b1;
        next_cyc();
        err_clr = 1'b0;
        #1 chk("to_err_clr", err_sts, 2'b00);
        txn(0, 2, 32'h0000_0055, ac, got, oth);
        chk("post_to_cyc", ac, 2);
        chk("post_to_rdata", got, 32'h0000_0055);
        #1 chk("post_to_err", err_sts, 2'b00);

        // slave ack on the final watchdog cycle wins
        txn(0, 8, 32'h0000_00AA, ac, got, oth);
        chk("edge_cyc", ac, 8);
        chk("edge_rdata", got, 32'h0000_00AA);
        #1 chk("edge_err", err_sts, 2'b00);

        // err_clr held while requester 1 times out: its bit sets, bit 0 clears
        txn(0, 0, 32'h0, ac, got, oth);
        #1 chk("setwin_pre", err_sts, 2'b01);
        err_clr = 1'b1;
        txn(1, 0, 32'h0, ac, got, oth);
        err_clr = 1'b0;
        chk("setwin_cyc", ac, 8);
        chk("setwin_rdata", got, ERR);
        #1 chk("setwin_err", err_sts, 2'b10);
        err_clr = 1'b1;
        next_cyc();
        err_clr = 1'b0;

        // ---------------- requester abort ----------------
        m0_reg_cs = 1'b1;
        #3 chk("ab_idle0", s_reg_cs, 1'b0);
        next_cyc();
        #3 chk("ab_busy", s_reg_cs, 1'b1);
        next_cyc();
        m0_reg_cs = 1'b0;
        #3 chk("ab_drop", {s_reg_cs, m0_reg_ack, m1_reg_ack}, 3'b000);
        next_cyc();
        m0_reg_cs = 1'b1; m1_reg_cs = 1'b1;
        #3 chk("ab_idle1", {s_reg_cs, m0_reg_ack, err_sts}, 4'b0);
        next_cyc();
        #3 chk("ab_regrant", {s_reg_cs, s_reg_addr}, {1'b1, M1_ADDR});
        s_reg_ack = 1'b1; s_reg_rdata = 32'h0000_0033;
        #1 chk("ab_m1_ack", {m0_reg_ack, m1_reg_ack, m1_reg_rdata}, {2'b01, 32'h0000_0033});
        next_cyc();
        m0_reg_cs = 0; m1_reg_cs = 0; s_reg_ack = 0;
        next_cyc();

        // ---------------- reset mid-transaction ----------------
        m0_reg_cs = 1'b1;
        next_cyc();
        #1 chk("rst_pre_cs", s_reg_cs, 1'b1);
        s_reg_ack = 1'b1; s_reg_rdata = 32'h0000_0099;
        #1 chk("rst_pre_ack", m0_reg_ack, 1'b1);
        reset = 1'b1;
        #1 chk("rst_mid", outs(), '0);
        m0_reg_cs = 0; s_reg_ack = 0;
        @(posedge mclk);
        #1 reset = 1'b0;
        m1_reg_cs = 1'b1;
        #3 chk("rst_idle", s_reg_cs, 1'b0);
        next_cyc();
        #3 chk("rst_m1_gnt", {s_reg_cs, s_reg_addr}, {1'b1, M1_ADDR});
        s_reg_ack = 1'b1; s_reg_rdata = 32'h0000_0077;
        #1 chk("rst_m1_ack", {m1_reg_ack, m1_reg_rdata}, {1'b1, 32'h0000_0077});
        next_cyc();
        m1_reg_cs = 0; s_reg_ack = 0;
        next_cyc();
        m0_reg_cs = 1'b1; m1_reg_cs = 1'b1;
        next_cyc();
        #3 chk("rst_both_m0", {s_reg_cs, s_reg_addr}, {1'b1, M0_ADDR});
        m0_reg_cs = 0; m1_reg_cs = 0;

        // ---------------- randomized run vs reference model ----------------
        begin
            bit          act[2];
            logic        wr_r[2];
            logic [10:0] ad_r[2];
            logic [31:0] wd_r[2];
            logic [3:0]  be_r[2];
            bit          owned;      // a transaction currently holds the bus
            int          owner;      // which requester holds it
            int          age;        // 1-based BUSY cycle count of the transaction
            int          last;       // requester served most recently
            logic [1:0]  merr;
            bit          n_owned;
            int          n_owner, n_age, n_last;
            logic [1:0]  ack_e, err_hit;
            logic [31:0] rd_e;
            logic [127:0] exp_o;

            do_reset();
            owned = 0; owner = 0; age = 0; last = 1; merr = 2'b00;
            act[0] = 0; act[1] = 0; ja[0] = 0; ja[1] = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                for (int r = 0; r < 2; r++) begin
                    if (ja[r]) act[r] = 0;
                    else if (act[r] && ($urandom % 24 == 0)) act[r] = 0;
                    else if (!act[r] && ($urandom % 2 == 1)) begin
                        act[r] = 1;
                        wr_r[r] = 1'($urandom);
                        ad_r[r] = 11'($urandom);
                        wd_r[r] = $urandom;
                        be_r[r] = 4'($urandom);
                    end
                end
                m0_reg_cs = act[0]; m0_reg_wr = wr_r[0]; m0_reg_addr = ad_r[0];
                m0_reg_wdata = wd_r[0]; m0_reg_be = be_r[0];
                m1_reg_cs = act[1]; m1_reg_wr = wr_r[1]; m1_reg_addr = ad_r[1];
                m1_reg_wdata = wd_r[1]; m1_reg_be = be_r[1];
                s_reg_ack = ($urandom % 4 == 0);
                s_reg_rdata = $urandom;
                err_clr = ($urandom % 16 == 0);
                #3;

                ack_e = 2'b00; err_hit = 2'b00; rd_e = 32'h0;
                n_owned = owned; n_owner = owner; n_age = age; n_last = last;
                if (owned) begin
                    exp_o = pack(act[owner], wr_r[owner], ad_r[owner], wd_r[owner], be_r[owner],
                                 1'b0, 32'h0, 1'b0, 32'h0);
                    if (s_reg_ack) begin
                        ack_e[owner] = 1'b1; rd_e = s_reg_rdata;
                        n_owned = 0; n_last = owner;
                    end else if (!act[owner]) begin
                        n_owned = 0; n_last = owner;
                    end else if (age == T) begin
                        ack_e[owner] = 1'b1; rd_e = ERR; err_hit[owner] = 1'b1;
                        n_owned = 0; n_last = owner;
                    end else begin
                        n_age = age + 1;
                    end
                end else begin
                    exp_o = '0;
                    if (act[0] || act[1]) begin
                        n_owned = 1; n_age = 1;
                        n_owner = (act[0] && act[1]) ? 1 - last : (act[1] ? 1 : 0);
                    end
                end
                exp_o[65]    = ack_e[0];
                exp_o[64:33] = ack_e[0] ? rd_e : 32'h0;
                exp_o[32]    = ack_e[1];
                exp_o[31:0]  = ack_e[1] ? rd_e : 32'h0;
                chk($sformatf("rnd_out_c%0d", cyc), outs(), exp_o);
                chk($sformatf("rnd_err_c%0d", cyc), err_sts, merr);
                ja[0] = ack_e[0]; ja[1] = ack_e[1];
                next_cyc();
                owned = n_owned; owner = n_owner; age = n_age; last = n_last;
                merr = (err_clr ? 2'b00 : merr) | err_hit;
            end
            m0_reg_cs = 0; m1_reg_cs = 0; s_reg_ack = 0; err_clr = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
